winograd_tile_feeder: RTL and testbench

Input-side producer for the winograd2d F(2x2,3x3) engines. It accepts a raster pixel stream with a valid/ready handshake and buffers it in a 4-row circular line buffer. It then emits one 4-pixel tile column per cycle on the engine's r1_x..r4_x inputs, advancing two rows per band (stride-2 overlapping 4x4 tiles). It is the writer/producer end of the engine's column-stream input, which has no handshake.

---
 rtl/winograd_tile_feeder_if.sv | 23 ++
 rtl/winograd_tile_feeder.sv | 96 +++++++++
 tb/tb_winograd_tile_feeder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/winograd_tile_feeder_if.sv
// winograd_tile_feeder_if: pixel-stream input and tile-column output bundle of the feeder.
interface winograd_tile_feeder_if #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
);
  logic                        s_valid;
  logic                        s_ready;
  logic signed [DATA_W-1:0]    s_data;
  logic                        m_valid;
  logic signed [DATA_W-1:0]    r1_x, r2_x, r3_x, r4_x;
  logic [$clog2(IMG_W)-1:0]    m_col;
  logic [$clog2(IMG_H)-1:0]    m_band;
  logic                        m_first, m_last, frame_done;
  modport master (
    input  s_valid, s_data,
    output s_ready, m_valid, r1_x, r2_x, r3_x, r4_x, m_col, m_band, m_first, m_last, frame_done
  );
  modport slave (
    output s_valid, s_data,
    input  s_ready, m_valid, r1_x, r2_x, r3_x, r4_x, m_col, m_band, m_first, m_last, frame_done
  );
endinterface

// File: rtl/winograd_tile_feeder.sv
// winograd_tile_feeder: 4-row circular line buffer emitting stride-2 4-pixel tile columns per band.
module winograd_tile_feeder #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic clk,
  input  logic rst_n,
  winograd_tile_feeder_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int BW = $clog2(IMG_H);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int NB = (IMG_H - 2) / 2;
  typedef enum logic {FILL, EMIT} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [4][IMG_W];
  logic [CW-1:0] wr_col, col, col_nx;
  logic [RW-1:0] wr_row, wr_row_nx, freed, freed_nx;
  logic [BW-1:0] band, band_nx;
  logic [RW:0]   rows_done;
  logic [1:0]    base;
  logic          acc, row_end, emit_nx, last_nx;
  // at most four live rows; the slots being read are never offered for writing
  assign bus.s_ready = ((wr_row - freed) < RW'(4)) && (wr_row < RW'(IMG_H));
  assign acc       = bus.s_valid && bus.s_ready;
  assign row_end   = acc && (wr_col == CW'(IMG_W - 1));
  assign rows_done = {1'b0, wr_row} + (RW + 1)'(row_end);
  assign bus.m_valid = (state == EMIT);
  assign bus.m_col   = col;
  assign bus.m_band  = band;
  always_comb begin
    state_nx  = state;
    col_nx    = '0;
    band_nx   = band;
    freed_nx  = freed;
    wr_row_nx = wr_row + RW'(row_end);
    if (state == FILL) begin
      if (32'(rows_done) >= 2 * 32'(band) + 4) state_nx = EMIT;
    end else if (col != CW'(IMG_W - 1)) begin
      col_nx = col + 1'b1;
    end else if (32'(band) == NB - 1) begin
      state_nx  = FILL;
      band_nx   = '0;
      freed_nx  = '0;
      wr_row_nx = '0;
    end else begin
      band_nx  = band + 1'b1;
      freed_nx = freed + RW'(2);
      state_nx = (32'(rows_done) >= 2 * 32'(band) + 6) ? EMIT : FILL;
    end
  end
  assign emit_nx = (state_nx == EMIT);
  assign last_nx = emit_nx && (col_nx == CW'(IMG_W - 1));
  assign base    = {band_nx[0], 1'b0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      col    <= '0;
      band   <= '0;
      freed  <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else begin
      state  <= state_nx;
      col    <= col_nx;
      band   <= band_nx;
      freed  <= freed_nx;
      wr_row <= wr_row_nx;
      wr_col <= row_end ? '0 : wr_col + CW'(acc);
    end
  end
  // column c of the next band is read on the same edge the completing pixel lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r1_x       <= '0;
      bus.r2_x       <= '0;
      bus.r3_x       <= '0;
      bus.r4_x       <= '0;
      bus.m_first    <= 1'b0;
      bus.m_last     <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.r1_x       <= emit_nx ? mem[base][col_nx] : '0;
      bus.r2_x       <= emit_nx ? mem[base + 2'd1][col_nx] : '0;
      bus.r3_x       <= emit_nx ? mem[base + 2'd2][col_nx] : '0;
      bus.r4_x       <= emit_nx ? mem[base + 2'd3][col_nx] : '0;
      bus.m_first    <= emit_nx && (col_nx == '0);
      bus.m_last     <= last_nx;
      bus.frame_done <= last_nx && (32'(band_nx) == NB - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem[wr_row[1:0]][wr_col] <= bus.s_data;
  end
endmodule

// File: tb/tb_winograd_tile_feeder.sv
// tb_winograd_tile_feeder: directed frames with a queue scoreboard checked by an output monitor.
module tb_winograd_tile_feeder;
  localparam int W = 4;
  localparam int H = 6;
  typedef struct packed {
    logic [31:0] r1, r2, r3, r4;
    logic [1:0]  col;
    logic [2:0]  band;
    logic        first, last, done;
  } col_t;
  logic clk = 1'b0;
  logic rst_n;
  int tests, fails, frames_exp, fdone, run;
  bit was_last0;
  logic [31:0] img [H][W];
  col_t q [$];
  winograd_tile_feeder_if #(.DATA_W(32), .IMG_W(W), .IMG_H(H)) bus();
  winograd_tile_feeder #(.DATA_W(32), .IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic fill(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 32'(base + 16 * r + c);
  endtask
  task automatic push_cols(input int nb, input int ncol_last);
    col_t e;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < W && !(b == nb - 1 && c > ncol_last); c++) begin
        e.r1 = img[2*b][c]; e.r2 = img[2*b+1][c]; e.r3 = img[2*b+2][c]; e.r4 = img[2*b+3][c];
        e.col = 2'(c); e.band = 3'(b);
        e.first = (c == 0); e.last = (c == W - 1); e.done = (b == H/2 - 2) && (c == W - 1);
        q.push_back(e);
      end
  endtask
  task automatic push_frame();
    push_cols(H/2 - 1, W - 1);
    frames_exp++;
  endtask
  task automatic put(input logic [31:0] d, input bit bursty);
    int t = 0;
    bit ok;
    if (bursty) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    do begin
      ok = bus.s_ready;
      @(posedge clk); #1;
      t++;
    end while (!ok && t < 300);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL put timeout: s_ready stayed %b, required 1", bus.s_ready);
    end
    bus.s_valid = 1'b0;
  endtask
  task automatic send_rows(input int nrows, input bit bursty);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < W; c++) put(img[r][c], bursty);
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || bus.m_valid) && t < 500) begin
      @(posedge clk); t++;
    end
    tests++;
    if (t >= 500) begin
      fails++;
      $display("FAIL drain: %0d columns still pending, required 0", q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    col_t a, e;
    if (!rst_n) begin
      run = 0;
      was_last0 = 1'b0;
    end else begin
      if (was_last0) begin
        tests++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
          fails++;
          $display("FAIL after_band0: m_valid=%b s_ready=%b, required 0 1", bus.m_valid, bus.s_ready);
        end
      end
      if (bus.m_valid) begin
        run++;
        a = {bus.r1_x, bus.r2_x, bus.r3_x, bus.r4_x, bus.m_col, bus.m_band, bus.m_first, bus.m_last, bus.frame_done};
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_col: got %h, required no column", a);
        end else begin
          e = q.pop_front();
          if (a !== e || bus.s_ready !== 1'b0) begin
            fails++;
            $display("FAIL col b%0d c%0d: got %h ready=%b, required %h ready=0", e.band, e.col, a, bus.s_ready, e);
          end
        end
      end else if (run != 0) begin
        tests++;
        if (run != W) begin
          fails++;
          $display("FAIL run_len: got %0d, required %0d", run, W);
        end
        run = 0;
      end
      if (bus.frame_done) fdone++;
      was_last0 = bus.m_valid && bus.m_last && (bus.m_band == 3'd0);
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    tests = 0; fails = 0; frames_exp = 0; fdone = 0; run = 0;
    rst_n = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tests++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.r1_x !== 32'd0 || bus.m_first !== 1'b0 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset: m_valid=%b s_ready=%b r1=%h first=%b done=%b, required 0 1 0 0 0",
               bus.m_valid, bus.s_ready, bus.r1_x, bus.m_first, bus.frame_done);
    end
    fill(0); push_frame(); send_rows(H, 1'b0); drain();
    fill(0); push_frame(); send_rows(H, 1'b1); drain();
    fill(0); push_frame(); send_rows(H, 1'b0);
    fill(1000); push_frame(); send_rows(H, 1'b0); drain();
    fill(0); push_cols(1, 2); send_rows(4, 1'b0);
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!(bus.m_valid && bus.m_col == 2'd2) && t < 200);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (t >= 200 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: m_valid=%b s_ready=%b wait=%0d, required 0 1", bus.m_valid, bus.s_ready, t);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL reset_queue: %0d columns pending, required 0", q.size());
      q.delete();
    end
    fill(0); push_frame(); send_rows(H, 1'b0); drain();
    fill(0);
    img[0][1] = 32'h8000_0000; img[3][1] = 32'h7FFF_FFFF;
    img[0][2] = 32'h7FFF_FFFF; img[3][2] = 32'h8000_0000;
    push_frame(); send_rows(H, 1'b1); drain();
    tests++;
    if (fdone != frames_exp) begin
      fails++;
      $display("FAIL frame_done_count: got %0d, required %0d", fdone, frames_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
